// File: rtl/sd_regs_pkg.sv
// Register map, status bits and sequencer states
// for the sdc_controller command path.
package sd_regs_pkg;

  localparam logic [6:0] REG_ARG0   = 7'h00;
  localparam logic [6:0] REG_ARG1   = 7'h01;
  localparam logic [6:0] REG_ARG2   = 7'h02;
  localparam logic [6:0] REG_ARG3   = 7'h03;
  localparam logic [6:0] REG_FLAGS  = 7'h04;
  localparam logic [6:0] REG_CMD    = 7'h05;
  localparam logic [6:0] REG_STAT   = 7'h30;
  localparam logic [6:0] REG_BLKSZ  = 7'h48;
  localparam logic [6:0] REG_BLKCNT = 7'h1c;

  localparam int STAT_CC  = 0;
  localparam int STAT_ERR = 1;

  localparam logic [7:0] STAT_W1C = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WR,
    S_GAP,
    S_POLL,
    S_ACK,
    S_DONE
  } sd_seq_state_t;

endpackage

// File: rtl/sd_cmd_sequencer.sv
// SD command sequencer: request -> controller
// register burst -> status poll -> done.
module sd_cmd_sequencer
  import sd_regs_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 65536,
  parameter int          POLL_GAP    = 16,
  parameter logic [6:0]  STAT_ADDR   = REG_STAT,
  parameter logic [6:0]  BLKSZ_ADDR  = REG_BLKSZ,
  parameter logic [6:0]  BLKCNT_ADDR = REG_BLKCNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_cmd,
  input  logic [31:0] req_arg,
  input  logic [7:0]  req_flags,
  input  logic        req_data,
  output logic        done,
  output logic        err_cmd,
  output logic        err_timeout,
  output logic        busy,
  output logic [6:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  input  logic [7:0]  reg_rdata
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
  localparam logic [16:0] TMO_LIM = 17'(TIMEOUT_CYC);

  sd_seq_state_t state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic          ph_q, ph_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [16:0]   tmo_q, tmo_d;
  logic [5:0]    cmd_q, cmd_d;
  logic [31:0]   arg_q, arg_d;
  logic [7:0]    flags_q, flags_d;
  logic          errc_q, errc_d;
  logic          errt_q, errt_d;

  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [16:0] tmo_nxt;
  logic        tmo_hit;
  logic        stat_hit;
  logic        unused_rdata;

  assign tmo_nxt      = tmo_q + 17'd1;
  assign tmo_hit      = tmo_nxt >= TMO_LIM;
  assign stat_hit     = reg_rdata[STAT_CC] | reg_rdata[STAT_ERR];
  assign unused_rdata = ^reg_rdata[7:2];

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = ~req_ready;
  assign done        = (state_q == S_DONE);
  assign err_cmd     = done & errc_q;
  assign err_timeout = done & errt_q;

  // Write list: step 0..1 are the data pre-writes, 2..7 the command.
  always_comb begin
    wr_addr = REG_ARG0;
    wr_data = 8'h00;
    unique case (step_q)
      3'd0: begin wr_addr = BLKSZ_ADDR;  wr_data = 8'h00;        end
      3'd1: begin wr_addr = BLKCNT_ADDR; wr_data = 8'h01;        end
      3'd2: begin wr_addr = REG_CMD;     wr_data = {2'b00, cmd_q}; end
      3'd3: begin wr_addr = REG_FLAGS;   wr_data = flags_q;      end
      3'd4: begin wr_addr = REG_ARG3;    wr_data = arg_q[31:24]; end
      3'd5: begin wr_addr = REG_ARG2;    wr_data = arg_q[23:16]; end
      3'd6: begin wr_addr = REG_ARG1;    wr_data = arg_q[15:8];  end
      3'd7: begin wr_addr = REG_ARG0;    wr_data = arg_q[7:0];   end
    endcase
  end

  // Next state, counters and controller port drive.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    ph_d      = ph_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    flags_d   = flags_q;
    errc_d    = errc_q;
    errt_d    = errt_q;
    reg_addr  = 7'h00;
    reg_wdata = 8'h00;
    reg_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cmd_d   = req_cmd;
          arg_d   = req_arg;
          flags_d = req_flags;
          ph_d    = 1'b0;
          step_d  = req_data ? 3'd0 : 3'd2;
          state_d = req_data ? S_PRE : S_WR;
        end
      end
      S_PRE, S_WR: begin
        reg_addr  = wr_addr;
        reg_wdata = wr_data;
        reg_we    = ph_q;
        ph_d      = ~ph_q;
        if (ph_q) begin
          step_d = step_q + 3'd1;
          if (step_q == 3'd1) state_d = S_WR;
          if (step_q == 3'd7) begin
            state_d = S_GAP;
            gap_d   = '0;
            tmo_d   = '0;
          end
        end
      end
      S_GAP: begin
        tmo_d = tmo_nxt;
        if (tmo_hit) begin
          state_d = S_DONE;
          errc_d  = 1'b0;
          errt_d  = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_POLL;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_POLL: begin
        reg_addr = STAT_ADDR;
        tmo_d    = tmo_nxt;
        if (stat_hit) begin
          state_d = S_ACK;
          ph_d    = 1'b0;
          errc_d  = reg_rdata[STAT_ERR];
          errt_d  = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          errc_d  = 1'b0;
          errt_d  = 1'b1;
        end else begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_ACK: begin
        reg_addr  = STAT_ADDR;
        reg_wdata = STAT_W1C;
        reg_we    = ph_q;
        ph_d      = ~ph_q;
        if (ph_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      ph_q    <= 1'b0;
      gap_q   <= '0;
      tmo_q   <= '0;
      cmd_q   <= '0;
      arg_q   <= '0;
      flags_q <= '0;
      errc_q  <= 1'b0;
      errt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ph_q    <= ph_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      flags_q <= flags_d;
      errc_q  <= errc_d;
      errt_q  <= errt_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: controller model,
// scoreboard of expected writes/done events.
module tb_sd_cmd_sequencer;
  import sd_regs_pkg::*;

  localparam int TMO = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_cmd;
  logic [31:0] req_arg;
  logic [7:0]  req_flags;
  logic        req_data;
  logic        done;
  logic        err_cmd;
  logic        err_timeout;
  logic        busy;
  logic [6:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic [7:0]  reg_rdata;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_arg(req_arg),
    .req_flags(req_flags), .req_data(req_data),
    .done(done), .err_cmd(err_cmd),
    .err_timeout(err_timeout), .busy(busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rdata(reg_rdata)
  );

  typedef struct packed {
    logic       dn;
    logic [6:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  int  last_done = 0;
  int  launch = 0;
  int  set_cyc = 0;
  bit  lat_pend = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: status bits appear stat_dly cycles after
  // the reg-0 launch write; STAT writes are write-1-clear.
  logic [7:0] stat;
  logic [7:0] stat_val = 8'h00;
  int         stat_dly = -1;
  int         cd;

  assign reg_rdata = (reg_addr == REG_STAT) ? stat : 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      stat <= 8'h00;
      cd   <= -1;
    end else begin
      if (reg_we && reg_addr == REG_ARG0) begin
        cd      <= stat_dly;
        set_cyc <= 1 << 30;
      end else if (cd == 0) begin
        stat    <= stat | stat_val;
        set_cyc <= cyc;
        cd      <= -1;
      end else if (cd > 0) begin
        cd <= cd - 1;
      end
      if (reg_we && reg_addr == REG_STAT)
        stat <= stat & ~reg_wdata;
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic pop_chk(logic dn, logic [6:0] a, logic [7:0] d);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got dn=%0d addr=%h data=%h, required none",
               dn, a, d);
    end else begin
      e = sb.pop_front();
      if (e != {dn, a, d}) begin
        n_bad++;
        $display("FAIL event: got dn=%0d addr=%h data=%h, required dn=%0d addr=%h data=%h",
                 dn, a, d, e.dn, e.a, e.d);
      end
      if (dn && e.dn && e.d == 8'h01)
        chk("timeout_window", int'(cyc - launch >= TMO - 6 && cyc - launch <= TMO + 6), 1);
      else if (dn && e.dn)
        chk("done_after_status", int'(cyc > set_cyc), 1);
    end
  endtask

  // Monitor: every strobe and every done pulse pops the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we) begin
        if (lat_pend) begin
          chk("accept_to_strobe", cyc - acc_cyc, 2);
          lat_pend = 0;
        end
        if (reg_addr == REG_ARG0) launch = cyc;
        pop_chk(1'b0, reg_addr, reg_wdata);
      end
      if (done) begin
        last_done = cyc;
        pop_chk(1'b1, 7'h00, {6'b0, err_cmd, err_timeout});
      end
    end
  end

  // Reference: what the controller should see for one request.
  task automatic push_exp(logic [5:0] c, logic [31:0] g, logic [7:0] f,
                          logic dt, logic [7:0] sv, int dly);
    if (dt) begin
      sb.push_back({1'b0, REG_BLKSZ, 8'h00});
      sb.push_back({1'b0, REG_BLKCNT, 8'h01});
    end
    sb.push_back({1'b0, 7'd5, {2'b00, c}});
    sb.push_back({1'b0, 7'd4, f});
    for (int i = 3; i >= 0; i--)
      sb.push_back({1'b0, 7'(i), g[8*i +: 8]});
    if (dly < 0) begin
      sb.push_back({1'b1, 7'h00, 8'h01});
    end else begin
      sb.push_back({1'b0, REG_STAT, 8'h03});
      sb.push_back({1'b1, 7'h00, {6'b0, sv[1], 1'b0}});
    end
  endtask

  task automatic accept(logic [5:0] c, logic [31:0] g, logic [7:0] f,
                        logic dt, bit keep);
    @(negedge clk);
    req_cmd   = c;
    req_arg   = g;
    req_flags = f;
    req_data  = dt;
    req_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (req_ready) begin
        acc_cyc  = cyc;
        lat_pend = 1;
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready) return;
    end
    chk("idle_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run(logic [5:0] c, logic [31:0] g, logic [7:0] f,
                     logic dt, logic [7:0] sv, int dly);
    stat_val = sv;
    stat_dly = dly;
    push_exp(c, g, f, dt, sv, dly);
    accept(c, g, f, dt, 0);
    wait_idle();
  endtask

  initial begin
    bit found;
    int r;
    logic [7:0] sv;
    req_valid = 0;
    req_cmd   = '0;
    req_arg   = '0;
    req_flags = '0;
    req_data  = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_errs", {err_cmd, err_timeout}, 0);
    rst = 1'b0;

    run(6'd0, 32'h0, 8'h00, 1'b0, 8'h01, 40);
    run(6'd7, 32'h0020_0000, 8'h00, 1'b0, 8'h01, 60);
    run(6'd17, 32'h0000_1200, 8'h3D, 1'b1, 8'h01, 30);
    run(6'd13, 32'hDEAD_BEEF, 8'h15, 1'b0, 8'h00, -1);

    // Request held high through the busy window.
    stat_val = 8'h02;
    stat_dly = 50;
    push_exp(6'd55, 32'h1234_5678, 8'h11, 1'b0, 8'h02, 50);
    accept(6'd55, 32'h1234_5678, 8'h11, 1'b0, 1);
    req_cmd   = 6'd41;
    req_arg   = 32'h40FF_8000;
    req_flags = 8'h02;
    push_exp(6'd41, 32'h40FF_8000, 8'h02, 1'b0, 8'h02, 50);
    @(negedge clk);
    chk("ready_drop", req_ready, 0);
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (req_ready) found = 1;
      else @(negedge clk);
    end
    chk("second_accept", cyc, last_done + 1);
    acc_cyc  = cyc;
    lat_pend = 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle();

    // Reset during the reg-3 strobe.
    stat_val = 8'h01;
    stat_dly = 40;
    push_exp(6'd8, 32'hA5C3_0F1E, 8'h08, 1'b0, 8'h01, 40);
    accept(6'd8, 32'hA5C3_0F1E, 8'h08, 1'b0, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (reg_we && reg_addr == REG_ARG3) found = 1;
    end
    chk("rst_strobe_seen", int'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_we", reg_we, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_done", done, 0);
    sb.delete();
    lat_pend = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run(6'd8, 32'hA5C3_0F1E, 8'h08, 1'b0, 8'h01, 40);

    for (int k = 0; k < 10; k++) begin
      r  = int'($urandom_range(0, 9));
      sv = (r < 6) ? 8'h01 : (r < 8) ? 8'h02 : 8'h03;
      run(6'($urandom_range(0, 63)), $urandom, 8'($urandom),
          1'($urandom_range(0, 1)), sv,
          (r == 0) ? -1 : int'($urandom_range(1, 150)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
